// File: rtl/psrv32_pkg.sv
// Shared PSRV32 definitions: opcodes, ALU-op encoding and the ID/EX bundle.
package psrv32_pkg;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      alu_op_e     alu_op;
      logic        alu_src;
      logic        pc_src_a;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic        branch;
      logic        jump;
      logic [2:0]  funct3;
      logic        illegal;
   } id_ex_t;

   // alt selects SUB/SRA; the caller decides when instr[30] may be honoured.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/pipeline_regfile.sv
// 32x32 integer register file: two async read ports with WB write-through, one sync write port.
module pipeline_regfile
   import psrv32_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o
);

   logic [31:0] regs [32];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         regs <= '{default: '0};
      end else if (wb_en_i && wb_rd_i != '0) begin
         regs[wb_rd_i] <= wb_data_i;
      end
   end

   always_comb begin
      rs1_data_o = regs[rs1_i];
      if (rs1_i == '0) begin
         rs1_data_o = '0;
      end else if (wb_en_i && wb_rd_i == rs1_i) begin
         rs1_data_o = wb_data_i;
      end
   end

   always_comb begin
      rs2_data_o = regs[rs2_i];
      if (rs2_i == '0) begin
         rs2_data_o = '0;
      end else if (wb_en_i && wb_rd_i == rs2_i) begin
         rs2_data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/pipeline_decode.sv
// PSRV32 ID stage: instruction decode, immediate generation and register read into a registered ID/EX bundle.
module pipeline_decode
   import psrv32_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        valid_i,
   input  logic [31:0] instruction_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   output logic [31:0] imm_o,
   output logic [3:0]  alu_op_o,
   output logic        alu_src_o,
   output logic        pc_src_a_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        reg_write_o,
   output logic        branch_o,
   output logic        jump_o,
   output logic [2:0]  funct3_o,
   output logic        illegal_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_rdata, rs2_rdata;
   id_ex_t      dec;
   id_ex_t      bundle;

   assign opcode = instruction_i[6:0];
   assign funct3 = instruction_i[14:12];

   assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
   assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
   assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                   instruction_i[30:25], instruction_i[11:8], 1'b0};
   assign imm_u = {instruction_i[31:12], 12'b0};
   assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                   instruction_i[20], instruction_i[30:21], 1'b0};

   pipeline_regfile u_regfile (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .rs1_i      (instruction_i[19:15]),
      .rs2_i      (instruction_i[24:20]),
      .wb_en_i    (wb_en_i),
      .wb_rd_i    (wb_rd_i),
      .wb_data_i  (wb_data_i),
      .rs1_data_o (rs1_rdata),
      .rs2_data_o (rs2_rdata)
   );

   // Invalid input leaves dec all-zero, which is exactly a bubble.
   always_comb begin
      dec = '0;
      if (valid_i) begin
         dec.valid    = 1'b1;
         dec.pc       = pc_i;
         dec.rs1      = instruction_i[19:15];
         dec.rs2      = instruction_i[24:20];
         dec.rd       = instruction_i[11:7];
         dec.funct3   = funct3;
         dec.rs1_data = rs1_rdata;
         dec.rs2_data = rs2_rdata;
         case (opcode)
            OP_LUI: begin
               dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
               dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.pc_src_a = 1'b1;
               dec.reg_write = 1'b1;
            end
            OP_JAL: begin
               dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.pc_src_a = 1'b1;
               dec.jump = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JALR: begin
               dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.jump = 1'b1;
               dec.reg_write = 1'b1;
            end
            OP_BRANCH: begin
               dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
            end
            OP_LOAD: begin
               dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
               dec.reg_write = 1'b1;
            end
            OP_STORE: begin
               dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
            end
            OP_OP_IMM: begin
               dec.imm       = imm_i;
               dec.alu_op    = alu_from_funct3(funct3, instruction_i[30] && funct3 == 3'b101);
               dec.alu_src   = 1'b1;
               dec.reg_write = 1'b1;
            end
            OP_OP: begin
               dec.alu_op    = alu_from_funct3(funct3, instruction_i[30]);
               dec.reg_write = 1'b1;
            end
            OP_MISC_MEM: begin
            end
            default: dec.illegal = 1'b1;
         endcase
         if (dec.rd == '0) dec.reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         bundle <= '0;
      end else if (flush_i) begin
         bundle <= '0;
      end else if (!stall_i) begin
         bundle <= dec;
      end
   end

   assign valid_o     = bundle.valid;
   assign pc_o        = bundle.pc;
   assign rs1_o       = bundle.rs1;
   assign rs2_o       = bundle.rs2;
   assign rd_o        = bundle.rd;
   assign rs1_data_o  = bundle.rs1_data;
   assign rs2_data_o  = bundle.rs2_data;
   assign imm_o       = bundle.imm;
   assign alu_op_o    = bundle.alu_op;
   assign alu_src_o   = bundle.alu_src;
   assign pc_src_a_o  = bundle.pc_src_a;
   assign mem_read_o  = bundle.mem_read;
   assign mem_write_o = bundle.mem_write;
   assign reg_write_o = bundle.reg_write;
   assign branch_o    = bundle.branch;
   assign jump_o      = bundle.jump;
   assign funct3_o    = bundle.funct3;
   assign illegal_o   = bundle.illegal;

endmodule

// File: tb/tb_pipeline_decode.sv
// Scoreboard bench for pipeline_decode: random and directed stimulus against a behavioural decode model.
`timescale 1ns/1ps
module tb_pipeline_decode;
   import psrv32_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic [31:0] pc_i = '0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        wb_en_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic [31:0] rs1_data_o, rs2_data_o, imm_o;
   logic [3:0]  alu_op_o;
   logic        alu_src_o, pc_src_a_o, mem_read_o, mem_write_o, reg_write_o, branch_o, jump_o;
   logic [2:0]  funct3_o;
   logic        illegal_o;

   pipeline_decode dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .instruction_i(instruction_i),
      .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i),
      .wb_data_i(wb_data_i), .valid_o(valid_o), .pc_o(pc_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .rd_o(rd_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
      .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .pc_src_a_o(pc_src_a_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
      .branch_o(branch_o), .jump_o(jump_o), .funct3_o(funct3_o), .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [31:0] mregs [32];
   id_ex_t      mbundle;
   id_ex_t      expq [$];
   logic [158:0] act;

   assign act = {valid_o, pc_o, rs1_o, rs2_o, rd_o, rs1_data_o, rs2_data_o, imm_o, alu_op_o,
                 alu_src_o, pc_src_a_o, mem_read_o, mem_write_o, reg_write_o, branch_o, jump_o,
                 funct3_o, illegal_o};

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h want=%h", name, got, want);
   endtask

   function automatic logic [31:0] ref_read(input logic [4:0] a, input logic wen,
                                            input logic [4:0] wrd, input logic [31:0] wdat);
      if (a == 0) return 32'd0;
      if (wen && wrd == a) return wdat;
      return mregs[a];
   endfunction

   function automatic alu_op_e ref_alu(input logic [2:0] f3, input logic alt);
      alu_op_e tbl [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (alt && f3 == 3'd0) return ALU_SUB;
      if (alt && f3 == 3'd5) return ALU_SRA;
      return tbl[f3];
   endfunction

   function automatic id_ex_t ref_decode(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                         input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
      id_ex_t b;
      logic signed [31:0] s;
      logic [12:0] bi;
      logic [20:0] ji;
      b = '0;
      if (!v) return b;
      s  = $signed(ins) >>> 20;
      bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      b.valid = 1'b1; b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
      b.funct3 = ins[14:12];
      b.rs1_data = ref_read(ins[19:15], wen, wrd, wdat);
      b.rs2_data = ref_read(ins[24:20], wen, wrd, wdat);
      case (ins[6:0])
         7'h37: begin b.imm = ins & 32'hFFFFF000; b.alu_op = ALU_PASS_B; b.alu_src = 1; b.reg_write = 1; end
         7'h17: begin b.imm = ins & 32'hFFFFF000; b.alu_src = 1; b.pc_src_a = 1; b.reg_write = 1; end
         7'h6F: begin b.imm = 32'($signed(ji)); b.alu_src = 1; b.pc_src_a = 1; b.jump = 1; b.reg_write = 1; end
         7'h67: begin b.imm = s; b.alu_src = 1; b.jump = 1; b.reg_write = 1; end
         7'h63: begin b.imm = 32'($signed(bi)); b.alu_op = ALU_SUB; b.branch = 1; end
         7'h03: begin b.imm = s; b.alu_src = 1; b.mem_read = 1; b.reg_write = 1; end
         7'h23: begin b.imm = (s & ~32'h1F) | 32'(ins[11:7]); b.alu_src = 1; b.mem_write = 1; end
         7'h13: begin
            b.imm = s; b.alu_src = 1; b.reg_write = 1;
            b.alu_op = ref_alu(ins[14:12], ins[30] && ins[14:12] == 3'd5);
         end
         7'h33: begin b.alu_op = ref_alu(ins[14:12], ins[30]); b.reg_write = 1; end
         7'h0F: ;
         default: b.illegal = 1;
      endcase
      if (b.rd == 0) b.reg_write = 0;
      return b;
   endfunction

   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl, input logic wen, input logic [4:0] wrd,
                       input logic [31:0] wdat);
      id_ex_t d;
      @(negedge clk_i);
      valid_i = v; instruction_i = ins; pc_i = pc; stall_i = st; flush_i = fl;
      wb_en_i = wen; wb_rd_i = wrd; wb_data_i = wdat;
      d = ref_decode(v, ins, pc, wen, wrd, wdat);
      if (fl) mbundle = '0;
      else if (!st) mbundle = d;
      expq.push_back(mbundle);
      if (wen && wrd != 0) mregs[wrd] = wdat;
   endtask

   task automatic after_edge();
      @(posedge clk_i);
      #2;
   endtask

   always begin
      @(posedge clk_i);
      #1;
      if (reset_ni && expq.size() > 0) chk("bundle", 256'(act), 256'(expq.pop_front()));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ins;
      logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
      mregs = '{default: '0};
      mbundle = '0;
      #1;
      chk("reset_outputs", 256'(act), 256'd0);
      @(negedge clk_i);
      reset_ni = 1'b1;

      step(1, 32'h00500093, 32'h100, 0, 0, 0, 0, 0);
      after_edge();
      chk("addi", {rd_o, imm_o, alu_op_o, alu_src_o, reg_write_o, valid_o},
          {5'd1, 32'd5, 4'd0, 1'b1, 1'b1, 1'b1});

      step(1, 32'hFE000CE3, 32'h104, 0, 0, 0, 0, 0);
      after_edge();
      chk("beq", {imm_o, branch_o, alu_op_o, reg_write_o}, {32'hFFFFFFF8, 1'b1, 4'd1, 1'b0});

      step(1, 32'h002101B3, 32'h108, 0, 0, 1, 5'd2, 32'hDEADBEEF);
      after_edge();
      chk("bypass", {rs1_data_o, rs2_data_o}, {32'hDEADBEEF, 32'hDEADBEEF});

      step(1, 32'h00500093, 32'h10C, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      step(1, 32'h000001B3, 32'h110, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      after_edge();
      chk("x0_read", {rs1_data_o, rs2_data_o}, 64'd0);

      step(1, 32'h00700113, 32'h200, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, $urandom, $urandom, 1, 0, 0, 0, 0);
         after_edge();
         chk("stall_hold", {pc_o, imm_o, rd_o}, {32'h200, 32'd7, 5'd2});
      end

      step(1, 32'h00500093, 32'h204, 1, 1, 0, 0, 0);
      after_edge();
      chk("flush_stall", 256'(valid_o), 256'd0);

      step(1, 32'h000000F3, 32'h208, 0, 0, 0, 0, 0);
      after_edge();
      chk("illegal", {illegal_o, reg_write_o, valid_o}, 3'b101);

      // Write x5, then assert reset mid-stall away from any clock edge.
      step(1, 32'h00500093, 32'h20C, 0, 0, 1, 5'd5, 32'h12345678);
      step(1, 32'h00500093, 32'h210, 1, 0, 0, 0, 0);
      @(negedge clk_i);
      #2;
      reset_ni = 1'b0;
      #1;
      chk("async_reset", 256'(act), 256'd0);
      expq.delete();
      mregs = '{default: '0};
      mbundle = '0;
      valid_i = 0; stall_i = 0; flush_i = 0; wb_en_i = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_ni = 1'b1;
      step(1, 32'h005280B3, 32'h300, 0, 0, 0, 0, 0);
      after_edge();
      chk("x5_cleared", {rs1_data_o, rs2_data_o, valid_o}, {64'd0, 1'b1});

      for (int i = 0; i < 2000; i++) begin
         int unsigned k = $urandom_range(0, 11);
         ins = $urandom;
         ins[6:0] = (k == 11) ? 7'($urandom) : ops[k];
         if ($urandom_range(0, 3) != 0) begin
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
         end
         step($urandom_range(0, 7) != 0, ins, $urandom, $urandom_range(0, 7) == 0,
              $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 7)), $urandom);
      end

      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i);
      #3;
      chk("drain", 256'(expq.size()), 256'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
